regfile_write_sched: RTL
========================

// Module: regfile_write_sched
// PURPOSE
//  Schedules up to N_REQ result producers onto the single physical write port of the 64-entry physical register file.
//  Each requester owns a small FIFO. A round-robin arbiter drains at most one entry per cycle into the regfile write port.
//  Sits between the execution-unit result buses and the regfile (writeSelect0/writeData0, commitAllow).
// PARAMETERS
//  N_REQ   4   number of write requesters (execution result buses)
//  TAG_W   6   physical register select width (64 regs)
//  DATA_W  32  register data width
//  QDEPTH  2   entries per requester FIFO (power of 2, >=2)
// PORTS
//  clk          in   1             clock; all state updates on posedge
//  reset        in   1             asynchronous reset, active-low
//  en           in   1             global enable; 0 = freeze (no enqueue, no issue, no flush)
//  commitAllow  in   1             regfile write permitted this cycle
//  flush        in   1             synchronous clear of all pending writes
//  req_valid    in   N_REQ         per-requester write request
//  req_tag      in   N_REQ*TAG_W   per-requester target register; requester i at [i*TAG_W +: TAG_W]
//  req_data     in   N_REQ*DATA_W  per-requester write data; requester i at [i*DATA_W +: DATA_W]
//  req_ready    out  N_REQ         requester FIFO can accept this cycle
//  wr_en        out  1             write strobe to regfile (drives its commitAllow)
//  wr_sel       out  TAG_W         regfile writeSelect0
//  wr_data      out  DATA_W        regfile writeData0
//  wr_src       out  2             index of granted requester (log2 N_REQ)
//  idle         out  1             all FIFOs empty
// BEHAVIOUR
//  - Reset (reset==0, async): all FIFOs empty, rr_ptr=0.
//    Outputs during reset: req_ready=0, wr_en=0, wr_sel=0, wr_data=0, wr_src=0, idle=1.
//  - Enqueue: requester i accepted on an edge where req_valid[i] & req_ready[i] & en & !flush.
//  - req_ready[i] = !full[i] & en & reset.
//    - Depends on the count only, never on req_valid or the dequeue of the same cycle.
//    - A full FIFO stays not-ready even while it is being drained; there is no pass-through.
//  - Issue (combinational from FIFO heads): eligible = nonempty[i]. wr_en = en & commitAllow & !flush & |eligible.
//    - Winner = first eligible index at or after rr_ptr, wrapping modulo N_REQ.
//    - wr_sel, wr_data and wr_src come from the winner's head entry.
//    - When wr_en=0, wr_sel, wr_data and wr_src hold 0.
//  - Dequeue: on an edge with wr_en=1, pop the winner's head and set rr_ptr = winner+1 (mod N_REQ).
//    rr_ptr is unchanged when no write issues.
//  - Latency: an entry accepted at edge t can appear on wr_en in the cycle after t. The regfile write lands at edge t+1.
//  - Simultaneous enqueue and dequeue on one FIFO: both happen and the count is unchanged. Only possible when the FIFO is not full.
//  - flush=1 (with en=1): all counts go to 0 at the edge. That edge accepts no enqueue and issues no write.
//    flush overrides valid, commitAllow and rr_ptr; rr_ptr resets to 0.
//  - en=0: no state changes; wr_en=0; req_ready=0.
//  - Ordering:
//    - FIFO order is kept per requester.
//    - There is no ordering between requesters. The rename logic never has two in-flight writes to the same tag.
//  - Pointer wrap: FIFO rd/wr pointers are log2(QDEPTH) bits and wrap naturally.
//    The count is log2(QDEPTH)+1 bits, saturating at QDEPTH by construction.
//  - idle = all counts zero, registered-state derived with no combinational input path.
// STRUCTURE
//  - Shared package regfile_pkg holds N_PHYS_REGS=64, TAG_W=6, DATA_W=32 and the write-entry struct {tag, data}.
//    The regfile and this block share the package.
//  - One sub-module, wr_req_fifo, is instantiated N_REQ times.
//    - Parameters: QDEPTH, TAG_W, DATA_W.
//    - Ports: push, pop, clr, head, full, empty.
//  - Round-robin pick and rr_ptr live in the top level. No separate arbiter module.
// TESTING
//  - Reset mid-traffic: fill FIFOs 0 and 2, drop reset low mid-cycle.
//    -> Outputs go to reset values at once, idle=1. After release, req_ready=4'b1111 and there are no stale writes.
//  - Single requester: req1 writes tag 5 = 0xDEADBEEF with commitAllow=1.
//    -> Next cycle wr_en=1, wr_sel=5, wr_data=0xDEADBEEF, wr_src=1; rr_ptr becomes 2.
//  - Fairness: all 4 FIFOs hold 2 entries, commitAllow=1 continuously.
//    -> wr_src sequence is 0,1,2,3,0,1,2,3; idle=1 after 8 writes.
//  - Backpressure: commitAllow=0 while req0 sends 3 writes.
//    -> req_ready[0] drops after 2 accepted; the third request is held. Raising commitAllow drains in order.
//  - Full plus drain: FIFO0 full, commitAllow=1 and req_valid[0]=1 in the same cycle.
//    -> req_ready[0]=0 that cycle, the head issues, and req_ready[0]=1 the next cycle.
//  - Flush: FIFOs partially full, flush=1 with req_valid=4'b1111 and commitAllow=1.
//    -> wr_en=0 that cycle; next cycle idle=1 and rr_ptr=0; none of the flush-cycle requests are queued.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared physical register file constants and write-entry type
package regfile_pkg;

  localparam int N_PHYS_REGS = 64;
  localparam int TAG_W       = 6;
  localparam int DATA_W      = 32;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/wr_req_fifo.sv
// rtl/wr_req_fifo.sv - per-requester pending-write FIFO, head entry visible combinationally
module wr_req_fifo
  import regfile_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [TAG_W+DATA_W-1:0] pushData,
  input  logic                    pop,
  input  logic                    clr,
  output logic [TAG_W+DATA_W-1:0] head,
  output logic                    full,
  output logic                    empty
);

  localparam int PTR_W = $clog2(QDEPTH);

  logic [TAG_W+DATA_W-1:0] mem [QDEPTH];
  logic [PTR_W-1:0]        rdPtr;
  logic [PTR_W-1:0]        wrPtr;
  logic [PTR_W:0]          count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (clr) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= pushData;
  end

  assign head  = mem[rdPtr];
  assign full  = (count == (PTR_W+1)'(QDEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/regfile_write_sched.sv
// rtl/regfile_write_sched.sv - round-robin scheduler of result buses onto the single regfile write port
module regfile_write_sched
  import regfile_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = regfile_pkg::TAG_W,
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int QDEPTH = 2,
  parameter int SRC_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    commitAllow,
  input  logic                    flush,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    wr_en,
  output logic [TAG_W-1:0]        wr_sel,
  output logic [DATA_W-1:0]       wr_data,
  output logic [SRC_W-1:0]        wr_src,
  output logic                    idle
);

  logic [TAG_W+DATA_W-1:0] heads [N_REQ];
  logic [N_REQ-1:0]        full;
  logic [N_REQ-1:0]        empty;
  logic [N_REQ-1:0]        push;
  logic [N_REQ-1:0]        pop;
  logic [SRC_W-1:0]        rrPtr;
  logic [SRC_W-1:0]        winner;
  logic [TAG_W+DATA_W-1:0] winHead;
  logic                    clr;

  assign clr = en & flush;

  for (genvar i = 0; i < N_REQ; i++) begin : g_fifo
    // Readiness depends only on occupancy, so a full FIFO never accepts while draining.
    assign req_ready[i] = ~full[i] & en & reset;
    assign push[i]      = req_valid[i] & req_ready[i] & ~flush;
    assign pop[i]       = wr_en & (winner == SRC_W'(i));

    wr_req_fifo #(
      .QDEPTH (QDEPTH),
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push[i]),
      .pushData ({req_tag[i*TAG_W +: TAG_W], req_data[i*DATA_W +: DATA_W]}),
      .pop      (pop[i]),
      .clr      (clr),
      .head     (heads[i]),
      .full     (full[i]),
      .empty    (empty[i])
    );
  end

  // First non-empty requester at or after rrPtr, wrapping.
  always_comb begin
    int idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rrPtr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && !empty[idx]) begin
        found  = 1'b1;
        winner = idx[SRC_W-1:0];
      end
    end
  end

  assign winHead = heads[winner];
  assign wr_en   = en & commitAllow & ~flush & ~(&empty);
  assign wr_sel  = wr_en ? winHead[TAG_W+DATA_W-1 -: TAG_W] : '0;
  assign wr_data = wr_en ? winHead[DATA_W-1:0] : '0;
  assign wr_src  = wr_en ? winner : '0;
  assign idle    = &empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rrPtr <= '0;
    end else if (clr) begin
      rrPtr <= '0;
    end else if (wr_en) begin
      rrPtr <= (winner == SRC_W'(N_REQ-1)) ? '0 : winner + 1'b1;
    end
  end

endmodule
